wb_burst_master: RTL

WB_BURST_MASTER -- requirements
Module: wb_burst_master

---
 rtl/wb_burst_master.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_burst_master.sv
// Host-command to Wishbone burst master: ping, burst write and burst read with
// per-beat ack timeout and a latched interconnect interrupt reported as its own response.
module wb_burst_master #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          COUNT_WIDTH = 28,
    parameter int          TIMEOUT     = 200,
    parameter logic [31:0] PING_ID     = 32'hC594_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_ready,
    input  logic [31:0]             in_command,
    input  logic [ADDR_WIDTH-1:0]   in_address,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [COUNT_WIDTH-1:0]  in_data_count,
    output logic                    master_ready,
    input  logic                    out_ready,
    output logic                    out_en,
    output logic [31:0]             out_status,
    output logic [ADDR_WIDTH-1:0]   out_address,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [COUNT_WIDTH-1:0]  out_data_count,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_int_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]         TIMER_LOAD = TW'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] PING_DATA  = DATA_WIDTH'(PING_ID);
    localparam logic [15:0] CMD_PING  = 16'd0;
    localparam logic [15:0] CMD_WRITE = 16'd1;
    localparam logic [15:0] CMD_READ  = 16'd2;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_BUS, RD_BUS, RD_OUT, RESP, INT
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [COUNT_WIDTH-1:0]  remaining_reg, remaining_next;
    logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
    logic [TW-1:0]           timer_reg, timer_next;
    logic                    pend_reg, pend_next;
    logic                    int_prev_reg, int_prev_next;
    logic [31:0]             resp_status_reg, resp_status_next;
    logic [ADDR_WIDTH-1:0]   resp_addr_reg, resp_addr_next;
    logic [DATA_WIDTH-1:0]   resp_data_reg, resp_data_next;
    logic                    out_en_reg, out_en_next;
    logic [31:0]             out_status_reg, out_status_next;
    logic [ADDR_WIDTH-1:0]   out_address_reg, out_address_next;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    logic [COUNT_WIDTH-1:0]  out_count_reg, out_count_next;

    logic int_rise;
    logic timeout_hit;
    logic timed_state_cur, timed_state_next;
    logic unused_cmd_bits;

    // Only the low half of the command word carries meaning.
    assign unused_cmd_bits = ^in_command[31:16];

    assign int_rise         = wb_int_i & ~int_prev_reg;
    assign timeout_hit      = (timer_reg == TW'(1));
    assign timed_state_cur  = (state_reg == WR_BUS) || (state_reg == RD_BUS) || (state_reg == WR_DATA);
    assign timed_state_next = (state_next == WR_BUS) || (state_next == RD_BUS) || (state_next == WR_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            remaining_reg   <= '0;
            wdata_reg       <= '0;
            rdata_reg       <= '0;
            timer_reg       <= '0;
            pend_reg        <= 1'b0;
            int_prev_reg    <= 1'b0;
            resp_status_reg <= '0;
            resp_addr_reg   <= '0;
            resp_data_reg   <= '0;
            out_en_reg      <= 1'b0;
            out_status_reg  <= '0;
            out_address_reg <= '0;
            out_data_reg    <= '0;
            out_count_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            remaining_reg   <= remaining_next;
            wdata_reg       <= wdata_next;
            rdata_reg       <= rdata_next;
            timer_reg       <= timer_next;
            pend_reg        <= pend_next;
            int_prev_reg    <= int_prev_next;
            resp_status_reg <= resp_status_next;
            resp_addr_reg   <= resp_addr_next;
            resp_data_reg   <= resp_data_next;
            out_en_reg      <= out_en_next;
            out_status_reg  <= out_status_next;
            out_address_reg <= out_address_next;
            out_data_reg    <= out_data_next;
            out_count_reg   <= out_count_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        remaining_next   = remaining_reg;
        wdata_next       = wdata_reg;
        rdata_next       = rdata_reg;
        pend_next        = pend_reg | int_rise;
        int_prev_next    = wb_int_i;
        resp_status_next = resp_status_reg;
        resp_addr_next   = resp_addr_reg;
        resp_data_next   = resp_data_reg;
        out_en_next      = 1'b0;
        out_status_next  = out_status_reg;
        out_address_next = out_address_reg;
        out_data_next    = out_data_reg;
        out_count_next   = out_count_reg;

        case (state_reg)
            IDLE: begin
                if (in_ready) begin
                    addr_next        = in_address;
                    remaining_next   = (in_data_count == '0) ? COUNT_WIDTH'(1) : in_data_count;
                    resp_status_next = {16'h0000, ~in_command[15:0]};
                    resp_addr_next   = in_address;
                    resp_data_next   = '0;
                    case (in_command[15:0])
                        CMD_WRITE: begin
                            wdata_next = in_data;
                            state_next = WR_BUS;
                        end
                        CMD_READ:  state_next = RD_BUS;
                        CMD_PING: begin
                            resp_data_next = PING_DATA;
                            state_next     = RESP;
                        end
                        default:   state_next = RESP;
                    endcase
                end else if (pend_reg) begin
                    state_next = INT;
                end
            end
            WR_DATA: begin
                if (in_ready) begin
                    wdata_next = in_data;
                    state_next = WR_BUS;
                end else if (timeout_hit) begin
                    resp_status_next[31] = 1'b1;
                    resp_addr_next       = addr_reg;
                    state_next           = RESP;
                end
            end
            WR_BUS: begin
                // An ack in the final timer cycle still completes the beat.
                if (wb_ack_i) begin
                    addr_next = addr_reg + ADDR_WIDTH'(1);
                    if (remaining_reg != '0) begin
                        remaining_next = remaining_reg - COUNT_WIDTH'(1);
                    end
                    state_next = (remaining_reg <= COUNT_WIDTH'(1)) ? RESP : WR_DATA;
                end else if (timeout_hit) begin
                    resp_status_next[31] = 1'b1;
                    resp_addr_next       = addr_reg;
                    state_next           = RESP;
                end
            end
            RD_BUS: begin
                if (wb_ack_i) begin
                    rdata_next = wb_dat_i;
                    state_next = RD_OUT;
                end else if (timeout_hit) begin
                    resp_status_next[31] = 1'b1;
                    resp_addr_next       = addr_reg;
                    state_next           = RESP;
                end
            end
            RD_OUT: begin
                if (out_ready) begin
                    out_en_next      = 1'b1;
                    out_status_next  = resp_status_reg;
                    out_address_next = addr_reg;
                    out_data_next    = rdata_reg;
                    out_count_next   = remaining_reg - COUNT_WIDTH'(1);
                    remaining_next   = remaining_reg - COUNT_WIDTH'(1);
                    addr_next        = addr_reg + ADDR_WIDTH'(1);
                    state_next       = (remaining_reg > COUNT_WIDTH'(1)) ? RD_BUS : IDLE;
                end
            end
            RESP: begin
                if (out_ready) begin
                    out_en_next      = 1'b1;
                    out_status_next  = resp_status_reg;
                    out_address_next = resp_addr_reg;
                    out_data_next    = resp_data_reg;
                    out_count_next   = '0;
                    state_next       = IDLE;
                end
            end
            INT: begin
                if (out_ready) begin
                    out_en_next      = 1'b1;
                    out_status_next  = 32'h4000_0000;
                    out_address_next = '0;
                    out_data_next    = '0;
                    out_count_next   = '0;
                    // A fresh edge arriving while reporting stays pending.
                    pend_next        = int_rise;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        timer_next = timer_reg;
        if (timed_state_next && (state_next != state_reg)) begin
            timer_next = TIMER_LOAD;
        end else if (timed_state_cur && (timer_reg != '0)) begin
            timer_next = timer_reg - TW'(1);
        end
    end

    assign master_ready   = ~rst & ((state_reg == IDLE) || (state_reg == WR_DATA));
    assign wb_cyc_o       = (state_reg == WR_DATA) || (state_reg == WR_BUS) ||
                            (state_reg == RD_BUS)  || (state_reg == RD_OUT);
    assign wb_stb_o       = (state_reg == WR_BUS) || (state_reg == RD_BUS);
    assign wb_we_o        = (state_reg == WR_BUS);
    assign wb_sel_o       = wb_stb_o ? '1 : '0;
    assign wb_adr_o       = addr_reg;
    assign wb_dat_o       = wdata_reg;
    assign out_en         = out_en_reg;
    assign out_status     = out_status_reg;
    assign out_address    = out_address_reg;
    assign out_data       = out_data_reg;
    assign out_data_count = out_count_reg;

endmodule
